// File: rtl/score_display_sched.sv
// score_display_sched: scans a 3-digit seven-segment score display and
// shares it between two 8-bit score sources (player A / player B).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   score_a  in   player A score, binary 0..255
//   score_b  in   player B score, binary 0..255
//   upd_a    in   one-cycle pulse, A's score changed
//   upd_b    in   one-cycle pulse, B's score changed
//   ssd      out  segment pattern (gfedcba, active-high), 0 = dark
//   ssd_bit  out  one-hot digit enable: [2]=hundreds [1]=tens [0]=ones
//   src      out  source shown: 0 = A, 1 = B
module score_display_sched #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000,
    parameter int HOLD  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] score_a,
    input  logic [7:0] score_b,
    input  logic       upd_a,
    input  logic       upd_b,
    output logic [6:0] ssd,
    output logic [2:0] ssd_bit,
    output logic       src
);

    localparam int PW = $clog2(DIV);
    localparam int BW = $clog2(BLANK + 1);
    localparam int FW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [PW-1:0] PMAX  = PW'(DIV - 1);
    localparam logic [BW-1:0] BINIT = BW'(BLANK);
    localparam logic [FW-1:0] FMAX  = FW'(HOLD - 1);

    typedef enum logic [1:0] {
        DIG2 = 2'd0,
        DIG1 = 2'd1,
        DIG0 = 2'd2
    } dig_e;

    function automatic logic [11:0] bin_to_bcd(input logic [7:0] v);
        return {4'(v / 8'd100), 4'((v / 8'd10) % 8'd10), 4'(v % 8'd10)};
    endfunction

    function automatic logic [6:0] bcd_to_ssd(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    dig_e          dig_q, dig_d;
    logic [7:0]    val_q, val_d;
    logic          src_q, src_d;
    logic          pend_a_q, pend_a_d;
    logic          pend_b_q, pend_b_d;
    logic [6:0]    ssd_q, ssd_d;
    logic [2:0]    bit_q, bit_d;

    logic          tick, frame;
    logic          pa, pb, other, own;
    logic [11:0]   bcd;
    logic          lit;

    always_comb begin
        tick   = (pcnt_q == PMAX);
        frame  = tick && (dig_q == DIG0);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;

        dig_d   = dig_q;
        blank_d = blank_q;
        if (blank_q != '0) blank_d = blank_q - 1'b1;
        if (tick) begin
            blank_d = BINIT;
            case (dig_q)
                DIG2:    dig_d = DIG1;
                DIG1:    dig_d = DIG0;
                default: dig_d = DIG2;
            endcase
        end

        // Pulses landing on the boundary cycle join that arbitration.
        pa    = pend_a_q | upd_a;
        pb    = pend_b_q | upd_b;
        other = src_q ? pa : pb;
        own   = src_q ? pb : pa;

        src_d    = src_q;
        fcnt_d   = fcnt_q;
        pend_a_d = pa;
        pend_b_d = pb;
        val_d    = val_q;
        if (frame) begin
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
            if (other) begin
                src_d  = ~src_q;
                fcnt_d = '0;
            end else if (own) begin
                fcnt_d = '0;
            end else if (fcnt_q == FMAX) begin
                src_d  = ~src_q;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
            val_d = src_d ? score_b : score_a;
        end

        // Outputs are a function of next state so they register in step.
        bcd   = bin_to_bcd(val_d);
        ssd_d = '0;
        bit_d = '0;
        case (dig_d)
            DIG2:    lit = (bcd[11:8] != 4'd0);
            DIG1:    lit = (bcd[11:4] != 8'd0);
            default: lit = 1'b1;
        endcase
        if (lit && blank_d == '0) begin
            case (dig_d)
                DIG2: begin
                    bit_d = 3'b100;
                    ssd_d = bcd_to_ssd(bcd[11:8]);
                end
                DIG1: begin
                    bit_d = 3'b010;
                    ssd_d = bcd_to_ssd(bcd[7:4]);
                end
                default: begin
                    bit_d = 3'b001;
                    ssd_d = bcd_to_ssd(bcd[3:0]);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q   <= '0;
            blank_q  <= BINIT;
            fcnt_q   <= '0;
            dig_q    <= DIG2;
            val_q    <= '0;
            src_q    <= 1'b0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            ssd_q    <= '0;
            bit_q    <= '0;
        end else begin
            pcnt_q   <= pcnt_d;
            blank_q  <= blank_d;
            fcnt_q   <= fcnt_d;
            dig_q    <= dig_d;
            val_q    <= val_d;
            src_q    <= src_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            ssd_q    <= ssd_d;
            bit_q    <= bit_d;
        end
    end

    assign ssd     = ssd_q;
    assign ssd_bit = bit_q;
    assign src     = src_q;

endmodule
